// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request and response channels with fixed wait states.
// Optional DMEM_MISALIGN_ERR_EN: misaligned requests skip storage and respond with resp_err=1.
module dmem_responder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [31:0]             req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err
);

  localparam int unsigned STRB_W    = DATA_WIDTH / 8;
  localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q;
  logic                    write_q;
  logic [31:0]             addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]       wstrb_q;

  logic                    accept;
  logic                    access;
  logic                    handshake;
  logic                    misaligned;
  logic                    do_write;
  logic                    acc_write;
  logic [31:0]             acc_addr;
  logic [DATA_WIDTH-1:0]   acc_wdata;
  logic [STRB_W-1:0]       acc_wstrb;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic                    unused_addr_bits;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // With no wait states the access happens on the acceptance edge, straight from the request.
  always_comb begin
    if (WAIT_CYCLES == 0) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wstrb = req_wstrb;
    end else begin
      acc_write = write_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wstrb = wstrb_q;
    end
  end

  assign word_idx         = acc_addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{acc_addr[31:ADDR_WIDTH+2], acc_addr[1:0]};

`ifdef DMEM_MISALIGN_ERR_EN
  assign misaligned = (acc_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_ready = (state_q == S_IDLE) && !rst;
    accept    = 1'b0;
    access    = 1'b0;
    handshake = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            access  = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          access  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          handshake = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign resp_valid = (state_q == S_RESP);
  assign do_write   = access && acc_write && !misaligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      resp_rdata <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
        cnt_q   <= WAIT_LOAD;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (access) begin
        resp_rdata <= (!acc_write && !misaligned) ? mem[word_idx] : '0;
      end else if (handshake) begin
        resp_rdata <= '0;
      end
    end
  end

`ifdef DMEM_MISALIGN_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_err <= 1'b0;
    end else if (access) begin
      resp_err <= misaligned;
    end else if (handshake) begin
      resp_err <= 1'b0;
    end
  end
`else
  assign resp_err = 1'b0;
`endif

  // Storage is deliberately outside the reset domain; its contents survive rst.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (acc_wstrb[b]) begin
          mem[word_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, reset/backpressure sequences, and
// randomized traffic checked against a byte-addressed reference memory.
module tb_dmem_responder;

  localparam int WAIT_CYCLES = 2;
  localparam int ADDR_WIDTH  = 10;
  localparam int NBYTES      = 4 * (1 << ADDR_WIDTH);
`ifdef DMEM_MISALIGN_ERR_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  dmem_responder #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (ADDR_WIDTH),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference memory: flat byte array plus a "has been written" flag per byte.
  logic [7:0] ref_b [NBYTES];
  bit         ref_k [NBYTES];

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] erd;
    logic        eerr;
  } vec_t;

  vec_t        tbl [15];
  logic [31:0] rd;
  logic        er;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] erd, output logic eerr,
                       output logic [31:0] emask);
    int base;
    base  = int'(a[ADDR_WIDTH+1:2]) * 4;
    erd   = '0;
    eerr  = 1'b0;
    emask = '1;
    if (MIS && a[1:0] != 2'b00) begin
      eerr = 1'b1;
    end else if (w) begin
      for (int i = 0; i < 4; i++) begin
        if (s[i]) begin
          ref_b[base+i] = d[8*i +: 8];
          ref_k[base+i] = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        erd[8*i +: 8]   = ref_b[base+i];
        emask[8*i +: 8] = ref_k[base+i] ? 8'hFF : 8'h00;
      end
    end
  endtask

  task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int hold, input bit compete,
                      output logic [31:0] r, output logic e);
    logic [31:0] erd, emask;
    logic        eerr;
    int          n;
    model(w, a, d, s, erd, eerr, emask);
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    req_wstrb  = s;
    resp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_before_accept", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wstrb = 4'($urandom);
    n = 1;
    while (!resp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency_edges", n, WAIT_CYCLES + 1);
    r = resp_rdata;
    e = resp_err;
    chk("resp_rdata", r & emask, erd & emask);
    chk("resp_err", e, eerr);
    for (int i = 0; i < hold; i++) begin
      if (compete) begin
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = a;
        req_wdata = 32'hFFFF_FFFF;
        req_wstrb = 4'hF;
      end
      @(posedge clk);
      #1;
      chk("hold_resp_valid", resp_valid, 1);
      chk("hold_resp_rdata", resp_rdata, r);
      chk("hold_resp_err", resp_err, e);
      chk("hold_req_ready", req_ready, 0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    chk("post_hs_resp_valid", resp_valid, 0);
    chk("post_hs_req_ready", req_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0, 1'b0};
    tbl[3]  = '{1'b1, 32'h0000_0020, 32'h0000_00AA, 4'h1, 32'h0, 1'b0};
    tbl[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h1122_33AA, 1'b0};
    tbl[5]  = '{1'b1, 32'h0000_1020, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0};
    tbl[6]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0};
    tbl[7]  = '{1'b1, 32'h0000_0013, 32'h0000_0055, 4'hF, 32'h0, MIS};
    tbl[8]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, MIS ? 32'hDEAD_BEEF : 32'h0000_0055, 1'b0};
    tbl[9]  = '{1'b1, 32'h0000_0030, 32'h1234_5678, 4'hF, 32'h0, 1'b0};
    tbl[10] = '{1'b1, 32'h0000_0030, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0};
    tbl[11] = '{1'b0, 32'h0000_0030, 32'h0,         4'h0, 32'h1234_5678, 1'b0};
    tbl[12] = '{1'b0, 32'h0000_0022, 32'h0,         4'h0, MIS ? 32'h0 : 32'hCAFE_F00D, MIS};
    tbl[13] = '{1'b1, 32'hFFFF_F030, 32'h0000_AB00, 4'h2, 32'h0, 1'b0};
    tbl[14] = '{1'b0, 32'h0000_0030, 32'h0,         4'h0, 32'h1234_AB78, 1'b0};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wstrb  = '0;
    resp_ready = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_req_ready", req_ready, 1);
    chk("post_rst_resp_valid", resp_valid, 0);

    foreach (tbl[i]) begin
      xfer(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, 0, 1'b0, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].erd);
      chk($sformatf("vec%0d_err", i), er, tbl[i].eerr);
    end

    // Backpressure: response held 5 cycles while a competing store is presented.
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b1, rd, er);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, rd, er);
    chk("after_compete_rdata", rd, MIS ? 32'hDEAD_BEEF : 32'h0000_0055);

    // Reset while a store sits in WAIT: the store must never land.
    xfer(1'b1, 32'h40, 32'hA5A5_0001, 4'hF, 0, 1'b0, rd, er);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h40;
    req_wdata = 32'h0BAD_0BAD;
    req_wstrb = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("wait_req_ready", req_ready, 0);
    rst = 1'b1;
    #1;
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_resp_valid", resp_valid, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_release_req_ready", req_ready, 1);
    chk("midrst_release_resp_valid", resp_valid, 0);
    xfer(1'b0, 32'h40, 32'h0, 4'h0, 0, 1'b0, rd, er);
    chk("abandoned_store_rdata", rd, 32'hA5A5_0001);

    // Reset after the store committed (response pending): the data stays.
    xfer(1'b1, 32'h44, 32'h7777_1234, 4'hF, 2, 1'b0, rd, er);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h44;
    req_wdata = 32'h3141_5926;
    req_wstrb = 4'hF;
    begin
      logic [31:0] d0, d1;
      logic        d2;
      model(1'b1, 32'h44, 32'h3141_5926, 4'hF, d0, d2, d1);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (WAIT_CYCLES) @(posedge clk);
    #1;
    chk("committed_resp_valid", resp_valid, 1);
    rst = 1'b1;
    #1;
    chk("committed_rst_resp_valid", resp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    xfer(1'b0, 32'h44, 32'h0, 4'h0, 0, 1'b0, rd, er);
    chk("committed_store_rdata", rd, 32'h3141_5926);

    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      xfer(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3),
           1'($urandom_range(0, 1)), rd, er);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
